riscv_seq_alu: RTL and testbench

- Parametrised, handshaked successor to the combinational RISC-V datapath ALU.
- Keeps the existing ALUctl encodings and adds iterative unsigned multiply, divide and remainder, plus signed set-less-than.
- Sits between register-read and writeback in the multi-cycle datapath and stalls issue through a valid/ready handshake.
- Single-cycle ops finish in 1 cycle; MUL/DIVU/REMU take WIDTH cycles.

---
 rtl/riscv_seq_alu.sv | 117 +++++++++++
 tb/tb_riscv_seq_alu.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_seq_alu.sv
// rtl/riscv_seq_alu.sv - handshaked RISC-V ALU with iterative MUL/DIVU/REMU
module riscv_seq_alu #(
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0]    OP_MUL  = 4'd3;
  localparam logic [3:0]    OP_DIVU = 4'd4;
  localparam logic [3:0]    OP_REMU = 4'd5;
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op;
  logic [WIDTH-1:0] opa, opb, acc, rem;
  logic [WIDTH-1:0] single_res, acc_nxt, rem_nxt, quo_nxt, iter_res;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge, is_iter;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign is_iter   = (ALUctl == OP_MUL) || (ALUctl == OP_DIVU) || (ALUctl == OP_REMU);

  always_comb begin
    single_res = '0;
    case (ALUctl)
      4'd0:    single_res = A & B;
      4'd1:    single_res = A | B;
      4'd2:    single_res = A + B;
      4'd6:    single_res = A - B;
      4'd7:    single_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'd8:    single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd12:   single_res = ~(A | B);
      default: single_res = '0;
    endcase
  end

  // MUL shifts opa left / opb right; DIVU/REMU shifts the dividend out of opa
  // MSB first while the quotient bits shift in at the bottom.
  always_comb begin
    acc_nxt = acc + (opb[0] ? opa : '0);
    rem_sh  = {rem, opa[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, opb});
    rem_nxt = rem_ge ? WIDTH'(rem_sh - {1'b0, opb}) : rem_sh[WIDTH-1:0];
    quo_nxt = {opa[WIDTH-2:0], rem_ge};
    case (op)
      OP_MUL:  iter_res = acc_nxt;
      OP_DIVU: iter_res = quo_nxt;
      default: iter_res = rem_nxt;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      rem    <= '0;
      ALUOut <= '0;
      Zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op  <= ALUctl;
          opa <= A;
          opb <= B;
          acc <= '0;
          rem <= '0;
          cnt <= '0;
          if (is_iter) begin
            state <= BUSY;
          end else begin
            ALUOut <= single_res;
            Zero   <= (single_res == '0);
            state  <= DONE;
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (op == OP_MUL) begin
            acc <= acc_nxt;
            opa <= opa << 1;
            opb <= opb >> 1;
          end else begin
            rem <= rem_nxt;
            opa <= quo_nxt;
          end
          if (cnt == LAST) begin
            ALUOut <= iter_res;
            Zero   <= (iter_res == '0);
            state  <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_seq_alu.sv
// tb/tb_riscv_seq_alu.sv - randomized self-checking bench for riscv_seq_alu
module tb_riscv_seq_alu;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [3:0]  aluctl;
  logic [63:0] a, b, aluout;
  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_zero, n_busy;
  logic [3:0]  n_aluctl;
  logic [7:0]  n_a, n_b, n_aluout;

  riscv_seq_alu #(.WIDTH(64)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUctl(aluctl), .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
    .ALUOut(aluout), .Zero(zero), .busy(busy)
  );

  riscv_seq_alu #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .ALUctl(n_aluctl), .A(n_a), .B(n_b), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .ALUOut(n_aluout), .Zero(n_zero), .busy(n_busy)
  );

  int checks = 0;
  int passes = 0;

  function automatic logic [63:0] model(input int w, input logic [3:0] op,
                                        input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0] m, x, y, top, r;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x   = ai & m;
    y   = bi & m;
    top = 64'd1 << (w - 1);
    case (op)
      4'd0:    r = x & y;
      4'd1:    r = x | y;
      4'd2:    r = x + y;
      4'd6:    r = x - y;
      4'd7:    r = {63'd0, (x < y)};
      4'd8:    r = {63'd0, ((x ^ top) < (y ^ top))};
      4'd12:   r = ~(x | y);
      4'd3:    r = x * y;
      4'd4:    r = (y == 0) ? m : x / y;
      4'd5:    r = (y == 0) ? x : x % y;
      default: r = 64'd0;
    endcase
    return r & m;
  endfunction

  // edges: clock edges after the accept edge until out_valid is seen
  task automatic run_op(input bit narrow, input logic [3:0] op, input logic [63:0] x,
                        input logic [63:0] y, output logic [63:0] res, output logic z,
                        output int edges);
    @(negedge clock);
    if (narrow) begin
      n_in_valid = 1'b1; n_aluctl = op; n_a = x[7:0]; n_b = y[7:0];
    end else begin
      in_valid = 1'b1; aluctl = op; a = x; b = y;
    end
    @(negedge clock);
    in_valid = 1'b0; n_in_valid = 1'b0;
    aluctl = 4'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    n_aluctl = 4'($urandom); n_a = 8'($urandom); n_b = 8'($urandom);
    edges = 0;
    while (!(narrow ? n_out_valid : out_valid) && edges < 300) begin
      @(negedge clock);
      edges++;
    end
    res = narrow ? {56'd0, n_aluout} : aluout;
    z   = narrow ? n_zero : zero;
    out_ready = 1'b1; n_out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0; n_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b1; aluctl = 4'd2; a = 64'd1; b = 64'd1;
    n_in_valid = 1'b1; n_aluctl = 4'd2; n_a = 8'd1; n_b = 8'd1;
    repeat (2) @(negedge clock);
    reset = 1'b0; in_valid = 1'b0; n_in_valid = 1'b0;
    checks++; if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_flags: got %b want 100", {in_ready, out_valid, busy}); else passes++;
    checks++; if (aluout !== 64'd0) $display("FAIL reset_aluout: got %h want 0", aluout); else passes++;
    checks++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b want 1", zero); else passes++;
    checks++; if ({n_in_ready, n_out_valid, n_busy, n_zero, n_aluout} !== {4'b1001, 8'd0}) $display("FAIL reset_narrow: got %b %h want 1001 00", {n_in_ready, n_out_valid, n_busy, n_zero}, n_aluout); else passes++;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_no_accept: out_valid got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_single_directed;
    logic [3:0]  ops [6] = '{4'd2, 4'd6, 4'd12, 4'd15, 4'd8, 4'd7};
    logic [63:0] xs  [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] ys  [6] = '{64'd1, 64'd7, 64'd0, 64'h5678, 64'd1, 64'd1};
    logic [63:0] exs [6] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 64'd0};
    logic [63:0] res;
    logic        z;
    int          e;
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, ops[i], xs[i], ys[i], res, z, e);
      checks++; if (res !== exs[i]) $display("FAIL single_%0d_result: got %h want %h", i, res, exs[i]); else passes++;
      checks++; if (z !== (exs[i] == 64'd0)) $display("FAIL single_%0d_zero: got %b want %b", i, z, exs[i] == 64'd0); else passes++;
      checks++; if (e !== 0) $display("FAIL single_%0d_latency: got %0d want 0", i, e); else passes++;
    end
  endtask

  task automatic test_mul_timing;
    int n, busy_cycles, ready_seen;
    @(negedge clock);
    in_valid = 1'b1; aluctl = 4'd3; a = 64'h1_0000_0001; b = 64'h1_0000_0003;
    @(negedge clock);
    in_valid = 1'b0; a = 64'd0; b = 64'd0;
    n = 0; busy_cycles = 0; ready_seen = 0;
    while (!out_valid && n < 300) begin
      if (busy) busy_cycles++;
      if (in_ready) ready_seen++;
      @(negedge clock);
      n++;
    end
    checks++; if (n !== 64) $display("FAIL mul_latency: got %0d want 64", n); else passes++;
    checks++; if (busy_cycles !== 64) $display("FAIL mul_busy_cycles: got %0d want 64", busy_cycles); else passes++;
    checks++; if (ready_seen !== 0) $display("FAIL mul_in_ready_low: got %0d cycles high want 0", ready_seen); else passes++;
    checks++; if (aluout !== 64'h4_0000_0003) $display("FAIL mul_result: got %h want 4_0000_0003", aluout); else passes++;
    checks++; if (zero !== 1'b0) $display("FAIL mul_zero: got %b want 0", zero); else passes++;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_div;
    logic [3:0]  ops [4] = '{4'd4, 4'd5, 4'd4, 4'd5};
    logic [63:0] xs  [4] = '{64'd100, 64'd100, 64'h1234, 64'h1234};
    logic [63:0] ys  [4] = '{64'd7, 64'd7, 64'd0, 64'd0};
    logic [63:0] exs [4] = '{64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234};
    logic [63:0] res;
    logic        z;
    int          e;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, ops[i], xs[i], ys[i], res, z, e);
      checks++; if (res !== exs[i]) $display("FAIL div_%0d_result: got %h want %h", i, res, exs[i]); else passes++;
      checks++; if (z !== 1'b0) $display("FAIL div_%0d_zero: got %b want 0", i, z); else passes++;
      checks++; if (e !== 64) $display("FAIL div_%0d_latency: got %0d want 64", i, e); else passes++;
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] q;
    int n;
    q = model(64, 4'd4, 64'd1000, 64'd7);
    @(negedge clock);
    in_valid = 1'b1; aluctl = 4'd4; a = 64'd1000; b = 64'd7;
    @(negedge clock);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clock);
      n++;
    end
    in_valid = 1'b1; aluctl = 4'd2; a = 64'd40; b = 64'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++; if ({out_valid, in_ready, zero, aluout} !== {3'b100, q}) $display("FAIL stall_%0d: got v=%b r=%b z=%b %h want v=1 r=0 z=0 %h", i, out_valid, in_ready, zero, aluout, q); else passes++;
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    checks++; if ({in_ready, out_valid, aluout} !== {2'b10, q}) $display("FAIL release_idle: got r=%b v=%b %h want r=1 v=0 %h", in_ready, out_valid, aluout, q); else passes++;
    @(negedge clock);
    in_valid = 1'b0;
    checks++; if ({out_valid, aluout} !== {1'b1, 64'd42}) $display("FAIL release_next_op: got v=%b %h want v=1 2a", out_valid, aluout); else passes++;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy(input bit narrow, input int at);
    logic [63:0] res, ov_out;
    logic        z, ov, zz, rdy, bz;
    int          e;
    @(negedge clock);
    if (narrow) begin
      n_in_valid = 1'b1; n_aluctl = 4'd3; n_a = 8'hFF; n_b = 8'hFF;
    end else begin
      in_valid = 1'b1; aluctl = 4'd3; a = '1; b = '1;
    end
    @(negedge clock);
    in_valid = 1'b0; n_in_valid = 1'b0;
    repeat (at) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ov     = narrow ? n_out_valid : out_valid;
    ov_out = narrow ? {56'd0, n_aluout} : aluout;
    zz     = narrow ? n_zero : zero;
    rdy    = narrow ? n_in_ready : in_ready;
    bz     = narrow ? n_busy : busy;
    checks++; if ({ov, zz, rdy, bz} !== 4'b0110) $display("FAIL abort_w%0d_flags: got v=%b z=%b r=%b b=%b want 0110", narrow ? 8 : 64, ov, zz, rdy, bz); else passes++;
    checks++; if (ov_out !== 64'd0) $display("FAIL abort_w%0d_aluout: got %h want 0", narrow ? 8 : 64, ov_out); else passes++;
    run_op(narrow, 4'd2, 64'd2, 64'd3, res, z, e);
    checks++; if ({res, z, e} !== {64'd5, 1'b0, 32'd0}) $display("FAIL abort_w%0d_add: got %h z=%b lat=%0d want 5 z=0 lat=0", narrow ? 8 : 64, res, z, e); else passes++;
  endtask

  task automatic test_narrow_mul;
    logic [63:0] res;
    logic        z;
    int          e;
    run_op(1'b1, 4'd3, 64'h0F, 64'h11, res, z, e);
    checks++; if (res !== 64'hFF) $display("FAIL w8_mul_result: got %h want ff", res); else passes++;
    checks++; if (e !== 8) $display("FAIL w8_mul_latency: got %0d want 8", e); else passes++;
  endtask

  task automatic test_random(input bit narrow, input int iters);
    logic [3:0]  op;
    logic [63:0] x, y, res, exp;
    logic        z;
    int          w, e, exp_e;
    w = narrow ? 8 : 64;
    for (int i = 0; i < iters; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       y = 64'd0;
        1:       y = 64'($urandom_range(1, 15));
        default: y = {$urandom, $urandom};
      endcase
      exp   = model(w, op, x, y);
      exp_e = (op == 4'd3 || op == 4'd4 || op == 4'd5) ? w : 0;
      run_op(narrow, op, x, y, res, z, e);
      checks++; if (res !== exp) $display("FAIL rand_w%0d_%0d op=%0d a=%h b=%h: got %h want %h", w, i, op, x, y, res, exp); else passes++;
      checks++; if (z !== (exp == 64'd0)) $display("FAIL rand_w%0d_%0d_zero: got %b want %b", w, i, z, exp == 64'd0); else passes++;
      checks++; if (e !== exp_e) $display("FAIL rand_w%0d_%0d_latency op=%0d: got %0d want %0d", w, i, op, e, exp_e); else passes++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; aluctl = 4'd0; a = 64'd0; b = 64'd0;
    n_in_valid = 1'b0; n_out_ready = 1'b0; n_aluctl = 4'd0; n_a = 8'd0; n_b = 8'd0;
    test_reset;
    test_single_directed;
    test_mul_timing;
    test_div;
    test_backpressure;
    test_reset_mid_busy(1'b0, 30);
    test_reset_mid_busy(1'b1, 4);
    test_narrow_mul;
    test_random(1'b0, 40);
    test_random(1'b1, 30);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
